// File: rtl/pool_window_fetch_pkg.sv
// Shared types and window geometry for the 2x3 pooling window fetcher.
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } pool_state_e;

    localparam int WIN_W = 3;
    localparam int WIN_H = 2;
    localparam int WIN_N = WIN_W * WIN_H;

    // Offset of window element k from the window's top-left address.
    // Order: top row c..c+2, then bottom row c..c+2.
    function automatic int win_off(input int img_w, input logic [2:0] k);
        int o;
        o = 0;
        case (k)
            3'd0: o = 0;
            3'd1: o = 1;
            3'd2: o = 2;
            3'd3: o = img_w;
            3'd4: o = img_w + 1;
            3'd5: o = img_w + 2;
            default: o = 0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pool_window_fetch_if.sv
// BRAM read port and window output bundle of the pooling window fetcher.
//
// Handshake: win_valid rises once all six window bytes are captured and
// stays high, with ad0..ad5 and win_idx frozen, until win_ready is sampled
// high on a rising edge; that edge is the transfer. win_ready is ignored
// while win_valid is low. BRAM reads have one cycle of latency: bram_dout
// is valid the cycle after bram_en.
interface pool_window_fetch_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              win_valid;
    logic              win_ready;
    logic [DATA_W-1:0] ad0;
    logic [DATA_W-1:0] ad1;
    logic [DATA_W-1:0] ad2;
    logic [DATA_W-1:0] ad3;
    logic [DATA_W-1:0] ad4;
    logic [DATA_W-1:0] ad5;
    logic [ADDR_W-1:0] win_idx;

    modport master (
        output bram_en, bram_addr, win_valid, ad0, ad1, ad2, ad3, ad4, ad5, win_idx,
        input  bram_dout, win_ready
    );

    modport slave (
        input  bram_en, bram_addr, win_valid, ad0, ad1, ad2, ad3, ad4, ad5, win_idx,
        output bram_dout, win_ready
    );
endinterface

// File: rtl/pool_window_fetch_addr_gen.sv
// Window position counters: column, window row, row base address and
// raster window index, advanced with adders only. Exposes the values the
// counters will hold after this edge so the top can register addresses
// for the next window without a bubble.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int IMG_W     = 12,
    parameter int IMG_H     = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] nxt_base,
    output logic [ADDR_W-1:0] nxt_idx,
    output logic              last_win
);

    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - WIN_W);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(IMG_H / WIN_H - 1);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(WIN_W);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WIN_H * IMG_W);
    localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // Next counter values: clear on a new map, step one window on advance.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        idx_d      = idx_q;
        if (clear) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = BASE_INIT;
            idx_d      = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d      = '0;
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                col_d = col_q + COL_STEP;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= BASE_INIT;
            idx_q      <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            idx_q      <= idx_d;
        end
    end

    assign nxt_base = row_base_d + col_d;
    assign nxt_idx  = idx_d;
    assign last_win = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/pool_window_fetch.sv
// Pooling window fetcher: walks the input map in raster order of 2x3
// windows (stride 3 across, 2 down), reads the six bytes of each window
// from the BRAM and presents them to the max unit with valid/ready.
// Optional feature macro: POOL_STALL_CNT_EN adds a 16-bit saturating count
// of PRESENT cycles spent waiting on win_ready.
module pool_window_fetch
    import pool_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int IMG_W     = 12,
    parameter int IMG_H     = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output pool_state_e dbg_state,
`ifdef POOL_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    pool_window_fetch_if.master bus
);

    localparam longint unsigned MAP_END =
        longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H);

    if ((IMG_W % WIN_W) != 0) begin : g_bad_img_w
        $error("pool_window_fetch: IMG_W must be a multiple of 3");
    end
    if ((IMG_H % WIN_H) != 0) begin : g_bad_img_h
        $error("pool_window_fetch: IMG_H must be a multiple of 2");
    end
    if (MAP_END > (64'd1 << ADDR_W)) begin : g_bad_addr_w
        $error("pool_window_fetch: map does not fit in ADDR_W address bits");
    end

    pool_state_e       state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] ad_q [WIN_N];
    logic [DATA_W-1:0] ad_d [WIN_N];

    logic              start_acc;
    logic              advance;
    logic [ADDR_W-1:0] nxt_base;
    logic [ADDR_W-1:0] nxt_idx;
    logic              last_win;

    pool_addr_gen #(
        .ADDR_W   (ADDR_W),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_acc),
        .advance (advance),
        .nxt_base(nxt_base),
        .nxt_idx (nxt_idx),
        .last_win(last_win)
    );

    // Next state, data capture and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        start_acc = 1'b0;
        advance   = 1'b0;
        for (int i = 0; i < WIN_N; i++) begin
            ad_d[i] = ad_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_FETCH;
                    k_d       = 3'd0;
                end
            end
            ST_FETCH: begin
                // Read issued at k-1 returns now.
                if (k_q != 3'd0) begin
                    ad_d[k_q - 3'd1] = bus.bram_dout;
                end
                if (k_q == 3'd6) begin
                    state_d = ST_PRESENT;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_PRESENT: begin
                if (bus.win_ready) begin
                    if (last_win) begin
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_FETCH;
                        k_d     = 3'd0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_PRESENT);
        done_d  = (state_d == ST_DONE);
        en_d    = (state_d == ST_FETCH) && (k_d <= 3'd5);
        addr_d  = en_d ? (nxt_base + ADDR_W'(win_off(IMG_W, k_d))) : '0;
        valid_d = (state_d == ST_PRESENT);
        idx_d   = busy_d ? nxt_idx : '0;
        if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            for (int i = 0; i < WIN_N; i++) begin
                ad_d[i] = '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                ad_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            for (int i = 0; i < WIN_N; i++) begin
                ad_q[i] <= ad_d[i];
            end
        end
    end

`ifdef POOL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of PRESENT cycles without win_ready; kept after done.
    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if ((state_q == ST_PRESENT) && !bus.win_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;
    assign bus.bram_en   = en_q;
    assign bus.bram_addr = addr_q;
    assign bus.win_valid = valid_q;
    assign bus.win_idx   = idx_q;
    assign bus.ad0       = ad_q[0];
    assign bus.ad1       = ad_q[1];
    assign bus.ad2       = ad_q[2];
    assign bus.ad3       = ad_q[3];
    assign bus.ad4       = ad_q[4];
    assign bus.ad5       = ad_q[5];

endmodule

// File: tb/tb_pool_window_fetch.sv
// Directed bench for pool_window_fetch: a default 12x8 map instance and a
// 6x4 map at BASE_ADDR=100, each fed by a BRAM model with mem[a] = a[7:0].
module tb_pool_window_fetch;
    import pool_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;
    pool_state_e st_a, st_b;
`ifdef POOL_STALL_CNT_EN
    logic [15:0] stall_a, stall_b;
`endif

    pool_window_fetch_if #(.DATA_W(8), .ADDR_W(10)) ifa ();
    pool_window_fetch_if #(.DATA_W(8), .ADDR_W(10)) ifb ();

    pool_window_fetch #(
        .DATA_W(8), .ADDR_W(10), .IMG_W(12), .IMG_H(8), .BASE_ADDR(0)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .busy     (busy_a),
        .done     (done_a),
        .dbg_state(st_a),
`ifdef POOL_STALL_CNT_EN
        .stall_cnt(stall_a),
`endif
        .bus      (ifa.master)
    );

    pool_window_fetch #(
        .DATA_W(8), .ADDR_W(10), .IMG_W(6), .IMG_H(4), .BASE_ADDR(100)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .busy     (busy_b),
        .done     (done_b),
        .dbg_state(st_b),
`ifdef POOL_STALL_CNT_EN
        .stall_cnt(stall_b),
`endif
        .bus      (ifb.master)
    );

    // BRAM models: one-cycle read latency, contents = low address byte.
    always @(posedge clk) begin
        if (ifa.bram_en) ifa.bram_dout <= ifa.bram_addr[7:0];
        if (ifb.bram_en) ifb.bram_dout <= ifb.bram_addr[7:0];
    end

    // Accepted-window and done-pulse counters for instance A.
    int win_cnt_a = 0;
    int done_cnt_a = 0;
    always @(posedge clk) begin
        if (ifa.win_valid && ifa.win_ready) win_cnt_a <= win_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5);
        return {8'(e0), 8'(e1), 8'(e2), 8'(e3), 8'(e4), 8'(e5)};
    endfunction

    function automatic logic [47:0] win_a();
        return {ifa.ad0, ifa.ad1, ifa.ad2, ifa.ad3, ifa.ad4, ifa.ad5};
    endfunction

    function automatic logic [47:0] win_b();
        return {ifb.ad0, ifb.ad1, ifb.ad2, ifb.ad3, ifb.ad4, ifb.ad5};
    endfunction

    // ---------------- directed sequence ----------------
    int w0, d0, n;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.win_ready = 1'b1;
        ifb.win_ready = 1'b1;
        tick(3);

        // Reset state.
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_bram_en", ifa.bram_en, 0);
        chk("rst_bram_addr", ifa.bram_addr, 0);
        chk("rst_win_valid", ifa.win_valid, 0);
        chk("rst_ad", win_a(), 0);
        chk("rst_win_idx", ifa.win_idx, 0);
        chk("rst_state", st_a, ST_IDLE);
        rst_n = 1'b1;
        tick(2);

        // Run A: win_ready high throughout, second start at T+20 ignored.
        w0 = win_cnt_a;
        d0 = done_cnt_a;
        start_a = 1'b1;
        tick();                               // T+1
        start_a = 1'b0;
        chk("a_busy_t1", busy_a, 1);
        chk("a_en_t1", ifa.bram_en, 1);
        chk("a_addr_t1", ifa.bram_addr, 0);
        chk("a_valid_t1", ifa.win_valid, 0);
        chk("a_state_t1", st_a, ST_FETCH);
        tick(7);                              // T+8
        chk("a_valid_t8", ifa.win_valid, 1);
        chk("a_win0", win_a(), pk(0, 1, 2, 12, 13, 14));
        chk("a_idx0", ifa.win_idx, 0);
        tick(8);                              // T+16
        chk("a_win1", win_a(), pk(3, 4, 5, 15, 16, 17));
        chk("a_idx1", ifa.win_idx, 1);
        tick(4);                              // T+20
        start_a = 1'b1;
        tick();                               // T+21
        start_a = 1'b0;
        tick(19);                             // T+40
        chk("a_win4", win_a(), pk(24, 25, 26, 36, 37, 38));
        chk("a_idx4", ifa.win_idx, 4);
        tick(88);                             // T+128
        chk("a_win15", win_a(), pk(81, 82, 83, 93, 94, 95));
        chk("a_idx15", ifa.win_idx, 15);
        chk("a_done_t128", done_a, 0);
        tick();                               // T+129
        chk("a_done_t129", done_a, 1);
        chk("a_busy_t129", busy_a, 0);
        chk("a_valid_t129", ifa.win_valid, 0);
        tick();                               // T+130
        chk("a_done_t130", done_a, 0);
        chk("a_state_t130", st_a, ST_IDLE);
        chk("a_win_count", win_cnt_a - w0, 16);
        chk("a_done_count", done_cnt_a - d0, 1);

        // Run B: win_ready low for 5 cycles while window 2 is presented.
        tick(2);
        w0 = win_cnt_a;
        start_a = 1'b1;
        tick();                               // T+1
        start_a = 1'b0;
        tick(16);                             // T+17
        ifa.win_ready = 1'b0;
        tick(7);                              // T+24
        for (int i = 0; i < 5; i++) begin
            chk("b_stall_valid", ifa.win_valid, 1);
            chk("b_stall_win2", win_a(), pk(6, 7, 8, 18, 19, 20));
            chk("b_stall_idx2", ifa.win_idx, 2);
            chk("b_stall_no_en", ifa.bram_en, 0);
            if (i < 4) tick();
        end                                   // T+28
        tick();                               // T+29
        ifa.win_ready = 1'b1;
        chk("b_win2_t29", win_a(), pk(6, 7, 8, 18, 19, 20));
        tick();                               // T+30
        chk("b_valid_t30", ifa.win_valid, 0);
        chk("b_en_t30", ifa.bram_en, 1);
        chk("b_addr_t30", ifa.bram_addr, 9);
        tick(104);                            // T+134
        chk("b_done_t134", done_a, 1);
`ifdef POOL_STALL_CNT_EN
        chk("b_stall_cnt", stall_a, 5);
`endif
        tick();                               // T+135
        chk("b_done_t135", done_a, 0);
`ifdef POOL_STALL_CNT_EN
        chk("b_stall_hold", stall_a, 5);
`endif
        chk("b_win_count", win_cnt_a - w0, 16);

        // Run C: asynchronous reset mid-map, then a clean restart.
        tick(2);
        start_a = 1'b1;
        tick();                               // T+1
        start_a = 1'b0;
        tick(29);                             // T+30
        rst_n = 1'b0;
        #1;
        chk("c_rst_busy", busy_a, 0);
        chk("c_rst_en", ifa.bram_en, 0);
        chk("c_rst_addr", ifa.bram_addr, 0);
        chk("c_rst_valid", ifa.win_valid, 0);
        chk("c_rst_ad", win_a(), 0);
        chk("c_rst_idx", ifa.win_idx, 0);
        chk("c_rst_state", st_a, ST_IDLE);
        tick(2);
        rst_n = 1'b1;
        tick();
        start_a = 1'b1;
        tick();                               // T'+1
        start_a = 1'b0;
        tick(7);                              // T'+8
        chk("c_win0", win_a(), pk(0, 1, 2, 12, 13, 14));
        chk("c_idx0", ifa.win_idx, 0);
        n = 0;
        while (!done_a && n < 200) begin
            tick();
            n++;
        end
        chk("c_done_seen", done_a, 1);
        chk("c_done_cycle", n, 121);

        // Run D: 6x4 map at BASE_ADDR=100.
        tick(2);
        start_b = 1'b1;
        tick();                               // T+1
        start_b = 1'b0;
        chk("d_busy_t1", busy_b, 1);
        chk("d_en_t1", ifb.bram_en, 1);
        chk("d_addr_t1", ifb.bram_addr, 100);
        tick(7);                              // T+8
        chk("d_win0", win_b(), pk(100, 101, 102, 106, 107, 108));
        chk("d_idx0", ifb.win_idx, 0);
        tick(8);                              // T+16
        chk("d_win1", win_b(), pk(103, 104, 105, 109, 110, 111));
        tick(8);                              // T+24
        chk("d_win2", win_b(), pk(112, 113, 114, 118, 119, 120));
        tick(8);                              // T+32
        chk("d_win3", win_b(), pk(115, 116, 117, 121, 122, 123));
        chk("d_idx3", ifb.win_idx, 3);
        tick();                               // T+33
        chk("d_done_t33", done_b, 1);
        chk("d_state_t33", st_b, ST_DONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool_window_fetch.md
# pool_window_fetch

Sequencer that reads a 2×3 pooling window from the feature-map BRAM. It presents the six window bytes on `ad0`..`ad5` to the downstream six-input max unit. It walks the whole input map in raster order of windows, with stride 3 horizontally and 2 vertically. It sits between the input-map BRAM read port and the pooling compare stage.

## Interface
- `DATA_W`, 8: element width.
- `ADDR_W`, 10: BRAM address width. Must satisfy `BASE_ADDR + IMG_W*IMG_H - 1 < 2**ADDR_W`.
- `IMG_W`, 12: input map width. Must be a multiple of 3.
- `IMG_H`, 8: input map height. Must be a multiple of 2.
- `BASE_ADDR`, 0: BRAM address of map element (row 0, col 0).
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to pool one full map. Sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last window is accepted.
- `bram_en` out 1: BRAM read enable.
- `bram_addr` out ADDR_W: BRAM read address.
- `bram_dout` in DATA_W: read data, valid 1 cycle after `bram_en`.
- `win_valid` out 1: window bytes are valid.
- `win_ready` in 1: downstream accepts the window.
- `ad0`..`ad5` out DATA_W each: window bytes. `ad0..ad2` are the top row, columns c..c+2. `ad3..ad5` are the bottom row, columns c..c+2.
- `win_idx` out ADDR_W: raster index of the current window, `(r/2)*(IMG_W/3) + c/3`.

## Operation
- FSM states: IDLE, FETCH, PRESENT, DONE.
- **IDLE**: all outputs 0. `start`=1 loads the window row/col counters to 0 and moves to FETCH.
- **FETCH**: lasts 7 cycles, tracked by a 3-bit element counter k=0..6.
  - For k=0..5: `bram_en`=1 and `bram_addr` = `row_base + col + off[k]`. `off` = {0, 1, 2, IMG_W, IMG_W+1, IMG_W+2}.
  - `bram_dout` is captured into `ad[k-1]` on cycles k=1..6.
  - After k=6, move to PRESENT.
- **PRESENT**: `win_valid`=1. `ad*` and `win_idx` are held stable until `win_ready`=1.
  - On accept, if this was not the last window: advance col by 3. On wrap, reset col to 0, add `2*IMG_W` to `row_base` and advance row. Then return to FETCH.
  - On accept of the last window: go to DONE.
- **DONE**: `done`=1 and `busy`=0 for one cycle, then return to IDLE.
- Address arithmetic is incremental adders only, no multipliers. `row_base` is ADDR_W wide and starts at `BASE_ADDR`.
- `start` while not in IDLE is ignored.
- `win_ready` outside PRESENT is ignored.
- Reset asserted mid-operation forces IDLE with all outputs 0. An in-flight window is discarded.
- A `win_ready` held permanently high gives back-to-back windows with no extra bubble.

## Timing
- Reset values: `busy`, `done`, `bram_en`, `bram_addr`, `win_valid`, `ad0`..`ad5`, `win_idx` all 0.
- `start` is sampled at cycle T. `busy`=1 and the first `bram_en` occur at T+1. `win_valid` rises at T+8.
- Each window costs 7 FETCH cycles plus at least 1 PRESENT cycle, so 8 cycles minimum per window.
- With the defaults (16 windows) and `win_ready` tied high, `done` pulses at T+1+16*8 = T+129.
- All outputs are registered.

## Configuration
- `POOL_STALL_CNT_EN` defined:
  - Adds an output port `stall_cnt`, 16 bits.
  - It counts cycles in PRESENT with `win_ready`=0 and saturates at 0xFFFF.
  - It is cleared on an accepted `start` and on reset, and holds its value after `done`.
- `POOL_STALL_CNT_EN` undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `pool_pkg`:
  - State enum (IDLE/FETCH/PRESENT/DONE).
  - Window geometry constants `WIN_W`=3 and `WIN_H`=2.
  - `off[]` formula as a function of `IMG_W`.
- Sub-module `pool_addr_gen`: row/col/`row_base` counters, the last-window flag and `win_idx`. The FSM and data capture stay in the top.
- Elaboration-time checks on the `IMG_W`/`IMG_H` divisibility and the `ADDR_W` range.

## Test plan
- Defaults, BRAM model mem[a]=a[7:0], `win_ready`=1, `start` pulse:
  - Window 0: `ad0..5` = 0,1,2,12,13,14.
  - Window 1: 3,4,5,15,16,17.
  - Window 4: 24,25,26,36,37,38.
  - Window 15: 81,82,83,93,94,95, with `win_idx`=15.
  - `done` at T+129.
- `win_ready` held low 5 cycles on window 2: `ad*` and `win_idx`=2 stay stable and no `bram_en` occurs. With `POOL_STALL_CNT_EN`, `stall_cnt`=5 at `done`.
- `start` pulsed again at T+20 while busy: ignored. Exactly 16 windows and 1 `done`.
- `rst_n` driven low at T+30: all outputs read 0 immediately. A new `start` restarts at window 0 (ad0=0).
- `BASE_ADDR`=100, `IMG_W`=6, `IMG_H`=4: 4 windows. Window 0 reads addresses 100,101,102,106,107,108. Window 3 reads 115,116,117,121,122,123.
